// File: rtl/sram_arb_pkg.sv
// Shared definitions for the two-port SRAM arbiter: parameter defaults,
// arbitration-mode constants and the requester identifier type.
package sram_arb_pkg;

  localparam int unsigned AW_DEFAULT = 15;
  localparam int unsigned DW_DEFAULT = 64;

  localparam int unsigned PRIO_RR    = 0;
  localparam int unsigned PRIO_FIXED = 1;

  typedef enum logic {
    REQ_M0 = 1'b0,
    REQ_M1 = 1'b1
  } req_id_t;

endpackage

// File: rtl/sram_arb_rr2.sv
// Two-way arbiter: turns the request valids and the last-grant pointer into
// a one-hot grant, round-robin or fixed priority (m0 highest).
module sram_arb_rr2
  import sram_arb_pkg::*;
#(
  parameter int unsigned PRIO_MODE = PRIO_RR
) (
  input  logic [1:0] valid,
  input  req_id_t    last_id,
  output logic [1:0] grant
);

  always_comb begin
    grant = '0;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11: begin
        // On contention m0 wins unless it was the one granted last (RR only).
        if (PRIO_MODE == PRIO_FIXED || last_id == REQ_M1) grant = 2'b01;
        else                                              grant = 2'b10;
      end
      default: grant = '0;
    endcase
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one single-port SRAM between two requesters: zero-wait grant, request
// muxing onto the SRAM port, and a one-cycle-later response to the grantee.
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned AW        = AW_DEFAULT,
  parameter int unsigned DW        = DW_DEFAULT,
  parameter int unsigned PRIO_MODE = PRIO_RR
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            m0_req_valid,
  output logic            m0_req_ready,
  input  logic [AW-1:0]   m0_req_addr,
  input  logic [DW/8-1:0] m0_req_we,
  input  logic [DW-1:0]   m0_req_wdata,
  output logic            m0_resp_valid,
  output logic [DW-1:0]   m0_resp_rdata,
  input  logic            m1_req_valid,
  output logic            m1_req_ready,
  input  logic [AW-1:0]   m1_req_addr,
  input  logic [DW/8-1:0] m1_req_we,
  input  logic [DW-1:0]   m1_req_wdata,
  output logic            m1_resp_valid,
  output logic [DW-1:0]   m1_resp_rdata,
  output logic            ram_en,
  output logic [DW/8-1:0] ram_we,
  output logic [AW-1:0]   ram_addr,
  output logic [DW-1:0]   ram_din,
  input  logic [DW-1:0]   ram_dout
);

  logic [1:0]    grant;
  logic [1:0]    ready;
  logic          any_grant;
  req_id_t       gnt_id;
  req_id_t       last_id;
  req_id_t       resp_id;
  logic          resp_pend;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] din_q;
  logic [DW-1:0] rdata0_q;
  logic [DW-1:0] rdata1_q;

  sram_arb_rr2 #(
    .PRIO_MODE (PRIO_MODE)
  ) u_arb (
    .valid   ({m1_req_valid, m0_req_valid}),
    .last_id (last_id),
    .grant   (grant)
  );

  // Nothing is accepted while reset is held.
  assign ready        = rst_n ? grant : 2'b00;
  assign m0_req_ready = ready[0];
  assign m1_req_ready = ready[1];
  assign any_grant    = |ready;
  assign gnt_id       = ready[1] ? REQ_M1 : REQ_M0;

  // Address and data hold between grants; enables drop to zero.
  always_comb begin
    ram_en   = any_grant;
    ram_we   = '0;
    ram_addr = addr_q;
    ram_din  = din_q;
    if (ready[0]) begin
      ram_we   = m0_req_we;
      ram_addr = m0_req_addr;
      ram_din  = m0_req_wdata;
    end else if (ready[1]) begin
      ram_we   = m1_req_we;
      ram_addr = m1_req_addr;
      ram_din  = m1_req_wdata;
    end
  end

  // Gated by rst_n so a grant just before reset never surfaces as a response.
  assign m0_resp_valid = rst_n && resp_pend && (resp_id == REQ_M0);
  assign m1_resp_valid = rst_n && resp_pend && (resp_id == REQ_M1);
  assign m0_resp_rdata = m0_resp_valid ? ram_dout : rdata0_q;
  assign m1_resp_rdata = m1_resp_valid ? ram_dout : rdata1_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_id   <= REQ_M1;
      resp_id   <= REQ_M0;
      resp_pend <= 1'b0;
      addr_q    <= '0;
      din_q     <= '0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      resp_pend <= any_grant;
      if (any_grant) begin
        last_id <= gnt_id;
        resp_id <= gnt_id;
        addr_q  <= ram_addr;
        din_q   <= ram_din;
      end
      if (m0_resp_valid) rdata0_q <= ram_dout;
      if (m1_resp_valid) rdata1_q <= ram_dout;
    end
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Drives a round-robin and a fixed-priority arbiter with identical stimulus,
// each on its own SRAM model, against a transaction-level reference model.
module tb_sram_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        v0, v1;
  logic [14:0] a0, a1;
  logic [7:0]  w0, w1;
  logic [63:0] d0, d1;

  logic        rdy0 [2];
  logic        rdy1 [2];
  logic        rv0  [2];
  logic        rv1  [2];
  logic [63:0] rd0  [2];
  logic [63:0] rd1  [2];
  logic        en   [2];
  logic [7:0]  rwe  [2];
  logic [14:0] raddr[2];
  logic [63:0] rdin [2];
  logic [63:0] rdout[2];

  logic [63:0] sram [2][32768];

  // Reference model state, one copy per arbitration mode.
  logic [63:0] refm [2][32768];
  int          last_g   [2];
  logic [14:0] held_a   [2];
  logic [63:0] held_d   [2];
  bit          pend     [2];
  int          pend_id  [2];
  logic [63:0] pend_dat [2];
  logic [63:0] last_rd  [2][2];
  bit          rd_known [2][2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    sram_port_arbiter #(
      .AW        (15),
      .DW        (64),
      .PRIO_MODE (g)
    ) u_dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .m0_req_valid  (v0),
      .m0_req_ready  (rdy0[g]),
      .m0_req_addr   (a0),
      .m0_req_we     (w0),
      .m0_req_wdata  (d0),
      .m0_resp_valid (rv0[g]),
      .m0_resp_rdata (rd0[g]),
      .m1_req_valid  (v1),
      .m1_req_ready  (rdy1[g]),
      .m1_req_addr   (a1),
      .m1_req_we     (w1),
      .m1_req_wdata  (d1),
      .m1_resp_valid (rv1[g]),
      .m1_resp_rdata (rd1[g]),
      .ram_en        (en[g]),
      .ram_we        (rwe[g]),
      .ram_addr      (raddr[g]),
      .ram_din       (rdin[g]),
      .ram_dout      (rdout[g])
    );
  end

  function automatic logic [63:0] bmask(input logic [7:0] we);
    for (int b = 0; b < 8; b++) bmask[b*8 +: 8] = {8{we[b]}};
  endfunction

  // SRAM with registered output; a write echoes the updated word.
  always @(posedge clk) begin
    for (int m = 0; m < 2; m++) begin
      if (en[m]) begin
        if (rwe[m] != 8'h00) begin
          sram[m][raddr[m]] <= (sram[m][raddr[m]] & ~bmask(rwe[m])) | (rdin[m] & bmask(rwe[m]));
          rdout[m]          <= (sram[m][raddr[m]] & ~bmask(rwe[m])) | (rdin[m] & bmask(rwe[m]));
        end else begin
          rdout[m] <= sram[m][raddr[m]];
        end
      end
    end
  end

  task automatic chk(input int m, input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s mode=%0d observed=%h expected=%h", tag, m, obs, exp);
    end
  endtask

  // Compare one mode's outputs with the model, then advance the model past the edge.
  task automatic model_step(input int m);
    int          g;
    logic        expv [2];
    logic [14:0] ga;
    logic [7:0]  gw;
    logic [63:0] gd, old, merged;
    g = -1;
    if (rst_n) begin
      if (v0 && v1) g = (m == 1 || last_g[m] == 1) ? 0 : 1;
      else if (v0)  g = 0;
      else if (v1)  g = 1;
    end
    ga = (g == 0) ? a0 : (g == 1) ? a1 : held_a[m];
    gd = (g == 0) ? d0 : (g == 1) ? d1 : held_d[m];
    gw = (g == 0) ? w0 : (g == 1) ? w1 : 8'h00;
    chk(m, "m0_ready", 64'(rdy0[m]), 64'(g == 0));
    chk(m, "m1_ready", 64'(rdy1[m]), 64'(g == 1));
    chk(m, "ram_en",   64'(en[m]),   64'(g >= 0));
    chk(m, "ram_we",   64'(rwe[m]),  64'(gw));
    chk(m, "ram_addr", 64'(raddr[m]), 64'(ga));
    chk(m, "ram_din",  rdin[m],      gd);
    for (int n = 0; n < 2; n++) expv[n] = rst_n && pend[m] && (pend_id[m] == n);
    chk(m, "m0_resp_valid", 64'(rv0[m]), 64'(expv[0]));
    chk(m, "m1_resp_valid", 64'(rv1[m]), 64'(expv[1]));
    if (expv[0]) chk(m, "m0_resp_rdata", rd0[m], pend_dat[m]);
    else if (rd_known[m][0]) chk(m, "m0_rdata_hold", rd0[m], last_rd[m][0]);
    if (expv[1]) chk(m, "m1_resp_rdata", rd1[m], pend_dat[m]);
    else if (rd_known[m][1]) chk(m, "m1_rdata_hold", rd1[m], last_rd[m][1]);

    if (!rst_n) begin
      pend[m]   = 0;
      last_g[m] = 1;
      held_a[m] = '0;
      held_d[m] = '0;
      rd_known[m][0] = 0;
      rd_known[m][1] = 0;
    end else begin
      for (int n = 0; n < 2; n++) begin
        if (expv[n]) begin
          last_rd[m][n]  = pend_dat[m];
          rd_known[m][n] = 1;
        end
      end
      if (g >= 0) begin
        old    = refm[m][ga];
        merged = (old & ~bmask(gw)) | (gd & bmask(gw));
        refm[m][ga]  = merged;
        pend_dat[m]  = (gw == 8'h00) ? old : merged;
        pend[m]      = 1;
        pend_id[m]   = g;
        last_g[m]    = g;
        held_a[m]    = ga;
        held_d[m]    = gd;
      end else begin
        pend[m] = 0;
      end
    end
  endtask

  // One clock cycle: drive at the falling edge, check shortly after.
  task automatic cycle(input logic rn, input logic [1:0] v,
                       input logic [14:0] ia0, input logic [7:0] iw0, input logic [63:0] id0,
                       input logic [14:0] ia1, input logic [7:0] iw1, input logic [63:0] id1);
    @(negedge clk);
    rst_n = rn;
    v0 = v[0]; a0 = ia0; w0 = iw0; d0 = id0;
    v1 = v[1]; a1 = ia1; w1 = iw1; d1 = id1;
    #1;
    model_step(0);
    model_step(1);
  endtask

  task automatic idle(input logic rn);
    cycle(rn, 2'b00, '0, '0, '0, '0, '0, '0);
  endtask

  initial begin
    rst_n = 1'b0;
    v0 = 0; v1 = 0; a0 = '0; a1 = '0; w0 = '0; w1 = '0; d0 = '0; d1 = '0;
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 32768; i++) begin
        sram[m][i] = '0;
        refm[m][i] = '0;
      end
      sram[m][16] = 64'h1122334455667788;
      refm[m][16] = 64'h1122334455667788;
      last_g[m] = 1; held_a[m] = '0; held_d[m] = '0; pend[m] = 0;
      pend_id[m] = 0; pend_dat[m] = '0;
      rd_known[m][0] = 0; rd_known[m][1] = 0;
    end

    // Reset, with both valids high to show nothing is accepted.
    cycle(1'b0, 2'b11, 15'h0001, 8'h00, '0, 15'h0002, 8'h00, '0);
    idle(1'b0);
    for (int m = 0; m < 2; m++) begin
      chk(m, "rst_ram_en",   64'(en[m]),    64'd0);
      chk(m, "rst_ram_addr", 64'(raddr[m]), 64'd0);
      chk(m, "rst_ram_din",  rdin[m],       64'd0);
    end

    // m0 lone read of 0x0010.
    cycle(1'b1, 2'b01, 15'h0010, 8'h00, '0, '0, '0, '0);
    chk(0, "d_m0_ready", 64'(rdy0[0]), 64'd1);
    idle(1'b1);
    chk(0, "d_m0_resp", 64'(rv0[0]), 64'd1);
    chk(0, "d_m0_rdata", rd0[0], 64'h1122334455667788);
    chk(0, "d_m1_noresp", 64'(rv1[0]), 64'd0);

    // m1 partial byte write, then read back.
    cycle(1'b1, 2'b10, '0, '0, '0, 15'h7FFF, 8'h0F, 64'hAAAAAAAA_BBBBBBBB);
    cycle(1'b1, 2'b10, '0, '0, '0, 15'h7FFF, 8'h00, '0);
    idle(1'b1);
    chk(0, "d_m1_wr_rd", rd1[0], 64'h00000000_BBBBBBBB);
    chk(1, "d_m1_wr_rd", rd1[1], 64'h00000000_BBBBBBBB);

    // Contention straight after reset.
    idle(1'b0);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 2'b11, 15'(10 + i), 8'h00, '0, 15'(20 + i), 8'h00, '0);
      chk(0, "d_rr_alt_m0", 64'(rdy0[0]), 64'(i % 2 == 0));
      chk(0, "d_rr_alt_m1", 64'(rdy1[0]), 64'(i % 2 == 1));
    end
    idle(1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 2'b11, 15'(30 + i), 8'h00, '0, 15'(40 + i), 8'h00, '0);
      chk(1, "d_fix_m0", 64'(rdy0[1]), 64'd1);
      chk(1, "d_fix_m1", 64'(rdy1[1]), 64'd0);
    end
    cycle(1'b1, 2'b10, '0, '0, '0, 15'h002C, 8'h00, '0);
    chk(1, "d_fix_m1_late", 64'(rdy1[1]), 64'd1);

    // Idle cycles keep the port disabled.
    for (int i = 0; i < 3; i++) begin
      idle(1'b1);
      chk(0, "d_idle_we", 64'(rwe[0]), 64'd0);
    end

    // Reset in the cycle after a grant.
    cycle(1'b1, 2'b01, 15'h0005, 8'hFF, 64'hDEADBEEF_01234567, '0, '0, '0);
    idle(1'b0);
    chk(0, "d_rst_noresp", 64'(rv0[0]), 64'd0);
    idle(1'b1);
    for (int m = 0; m < 2; m++) begin
      chk(m, "d_post_rst_addr", 64'(raddr[m]), 64'd0);
      chk(m, "d_post_rst_din",  rdin[m],       64'd0);
      chk(m, "d_post_rst_resp", 64'(rv0[m]),   64'd0);
    end

    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 99) < 3) ? 1'b0 : 1'b1, 2'($urandom),
            15'($urandom_range(0, 31)), ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom), {$urandom, $urandom},
            15'($urandom_range(0, 31)), ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom), {$urandom, $urandom});
    end
    idle(1'b1);
    idle(1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
